// File: rtl/mult_div_unit.sv
// Signed multiply (radix-2 Booth) / divide (restoring, magnitude + sign fix) unit owning HI/LO.
// Latency: WIDTH+1 cycles from the start edge to done; DIV by zero reports div0+done one cycle after start.
// Backpressure: start is accepted only in IDLE; start while busy is dropped. Optional abort port: MULT_DIV_ABORT_EN.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
`ifdef MULT_DIV_ABORT_EN
   input  logic             abort,
`endif
   input  logic             reset_in,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam int BW = 2 * WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic             op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BW-1:0]    booth_q, booth_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             sign_r_q, sign_r_d;
   logic             sign_q_q, sign_q_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             div0_q, div0_d;

   logic             abort_w;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   upper_ext, mcand_ext, booth_sum;
   logic [BW-1:0]    booth_step;
   logic [WIDTH:0]   rem_shift, rem_trial;

`ifdef MULT_DIV_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Datapath for one iteration: Booth add/sub + arithmetic shift, and one restoring-divide step.
   always_comb begin
      a_mag = a[WIDTH-1] ? -a : a;
      b_mag = b[WIDTH-1] ? -b : b;

      // Upper half widened by one bit so -(most negative) still fits and the sign survives.
      upper_ext = {booth_q[BW-1], booth_q[BW-1:WIDTH+1]};
      mcand_ext = {mcand_q[WIDTH-1], mcand_q};
      case (booth_q[1:0])
         2'b01:   booth_sum = upper_ext + mcand_ext;
         2'b10:   booth_sum = upper_ext - mcand_ext;
         default: booth_sum = upper_ext;
      endcase
      // Concatenating the WIDTH+1-bit sum above the old low half is the arithmetic right shift.
      booth_step = {booth_sum, booth_q[WIDTH:1]};

      // rem < divisor <= 2^(WIDTH-1) always, so the shifted remainder never needs bit WIDTH.
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      rem_trial = rem_shift - {1'b0, dvsr_q};
   end

   // Next-state and register update logic for the IDLE/RUN/FIX sequence.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      booth_d  = booth_q;
      mcand_d  = mcand_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      sign_r_d = sign_r_q;
      sign_q_d = sign_q_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      div0_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op && (b == '0)) begin
                  // Divide by zero never enters RUN; HI/LO keep their previous result.
                  done_d = 1'b1;
                  div0_d = 1'b1;
               end else begin
                  state_d  = S_RUN;
                  op_d     = op;
                  cnt_d    = '0;
                  booth_d  = {{WIDTH{1'b0}}, b, 1'b0};
                  mcand_d  = a;
                  rem_d    = '0;
                  quo_d    = a_mag;
                  dvsr_d   = b_mag;
                  sign_r_d = a[WIDTH-1];
                  sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
               end
            end
         end
         S_RUN: begin
            if (abort_w) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (op_q) begin
                  if (!rem_trial[WIDTH]) begin
                     rem_d = rem_trial[WIDTH-1:0];
                     quo_d = {quo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_d = rem_shift[WIDTH-1:0];
                     quo_d = {quo_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  booth_d = booth_step;
               end
               if (cnt_q == LAST_ITER) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (abort_w) begin
               state_d = S_IDLE;
            end else begin
               if (op_q) begin
                  // Quotient truncates toward zero; remainder follows the dividend's sign.
                  lo_d = sign_q_q ? -quo_q : quo_q;
                  hi_d = sign_r_q ? -rem_q : rem_q;
               end else begin
                  {hi_d, lo_d} = booth_q[BW-1:1];
               end
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         state_q  <= S_IDLE;
         op_q     <= 1'b0;
         cnt_q    <= '0;
         booth_q  <= '0;
         mcand_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         sign_r_q <= 1'b0;
         sign_q_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         booth_q  <= booth_d;
         mcand_q  <= mcand_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         sign_r_q <= sign_r_d;
         sign_q_q <= sign_q_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         div0_q   <= div0_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand sequences for restart, reset and abort.
// Latency: checks done at WIDTH+1 edges after start, div-by-zero at one edge.
// Backpressure: checks that start while busy is ignored.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div0;
`ifdef MULT_DIV_ABORT_EN
   logic        abort;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] prev_hi;
   logic [31:0] prev_lo;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
`ifdef MULT_DIV_ABORT_EN
      .abort    (abort),
`endif
      .reset_in (reset_in),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div0     (div0)
   );

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_div0;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one op, wait for done (bounded), and check result, latency, busy span and pulse width.
   task automatic do_op(input int idx, input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed0);
      int  k;
      int  busy_cnt;
      bit  seen;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      k = 0; busy_cnt = 0; seen = 0;
      while (!seen && k < 100) begin
         if (done) begin
            seen = 1;
         end else begin
            if (busy) busy_cnt++;
            if (k == 10) begin
               check($sformatf("v%0d hold_hi_while_busy", idx), hi, prev_hi);
               check($sformatf("v%0d hold_lo_while_busy", idx), lo, prev_lo);
            end
            @(negedge clk);
            k++;
         end
      end
      check($sformatf("v%0d done_seen", idx), seen, 1);
      check($sformatf("v%0d latency", idx), k, ed0 ? 0 : 33);
      check($sformatf("v%0d busy_cycles", idx), busy_cnt, ed0 ? 0 : 33);
      check($sformatf("v%0d busy_at_done", idx), busy, 0);
      check($sformatf("v%0d div0", idx), div0, ed0);
      check($sformatf("v%0d hi", idx), hi, eh);
      check($sformatf("v%0d lo", idx), lo, el);
      @(negedge clk);
      check($sformatf("v%0d done_one_cycle", idx), done, 0);
      check($sformatf("v%0d div0_one_cycle", idx), div0, 0);
      prev_hi = eh;
      prev_lo = el;
   endtask

   initial begin
      int done_cnt;
      int done_k;

      vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'h0000_0001, 32'hFFFF_FFFD, 1'b1};
      vecs[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[6]  = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
      vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
      vecs[8]  = '{1'b1, 32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0};
      vecs[9]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0};
      vecs[10] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[11] = '{1'b1, 32'd3,          32'd5,          32'h0000_0003, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 32'd0,          32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};

      reset_in = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
`ifdef MULT_DIV_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset_in = 1'b0;
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset div0", div0, 0);
      prev_hi = '0;
      prev_lo = '0;

      for (int i = 0; i < 13; i++) begin
         do_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_div0);
      end

      // Second start at edge 5 of a running MULT must be dropped: exactly one done, MULT result.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0; done_k = -1;
      for (int k = 0; k <= 60; k++) begin
         if (k > 0) @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (k == 4) begin
            start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
         end
         if (k == 5) start = 1'b0;
      end
      check("restart done_count", done_cnt, 1);
      check("restart done_latency", done_k, 33);
      check("restart hi", hi, 32'h0);
      check("restart lo", lo, 32'd12);
      check("restart busy_after", busy, 0);
      prev_hi = 32'h0;
      prev_lo = 32'd12;

      // Reset asserted at RUN edge 10 clears everything; a fresh op afterwards completes.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset_in = 1'b1;
      @(negedge clk);
      reset_in = 1'b0;
      check("midreset hi", hi, 0);
      check("midreset lo", lo, 0);
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset div0", div0, 0);
      prev_hi = '0;
      prev_lo = '0;
      do_op(100, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

`ifdef MULT_DIV_ABORT_EN
      // Abort at RUN edge 20: back to IDLE with no done and HI/LO untouched.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort no_done_later", done_cnt, 0);
      check("abort hi", hi, prev_hi);
      check("abort lo", lo, prev_lo);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
